// File: rtl/inst_dec_pkg.sv
// Shared types for the RV32I decode stage: format codes, opcode constants,
// skid-buffer state encoding and the decoded-bundle struct.
package inst_dec_pkg;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_ILL = 3'd7
  } fmt_e;

  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;

  // Encoding is {skid_v, main_v}, so the valid bits are read straight off the state.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_FULL1 = 2'b01,
    ST_FULL2 = 2'b11
  } skid_state_e;

  typedef struct packed {
    fmt_e       fmt;
    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;
  } dec_fields_t;

  function automatic fmt_e opcode_fmt(input logic [6:0] opc);
    fmt_e f;
    case (opc)
      OPC_OP:                                    f = FMT_R;
      OPC_OP_IMM, OPC_LOAD, OPC_JALR,
      OPC_SYSTEM, OPC_MISC_MEM:                  f = FMT_I;
      OPC_STORE:                                 f = FMT_S;
      OPC_BRANCH:                                f = FMT_B;
      OPC_LUI, OPC_AUIPC:                        f = FMT_U;
      OPC_JAL:                                   f = FMT_J;
      default:                                   f = FMT_ILL;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/inst_dec_fields.sv
// Combinational RV32I classifier: extracts register/function fields per format
// and assembles the sign-extended immediate at XLEN bits.
module inst_dec_fields
  import inst_dec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     i_inst,
  output dec_fields_t     o_fields,
  output logic [XLEN-1:0] o_imm
);

  fmt_e        w_fmt;
  logic [31:0] w_imm32;

  always_comb begin
    w_fmt    = (i_inst[1:0] == 2'b11) ? opcode_fmt(i_inst[6:0]) : FMT_ILL;
    o_fields = '0;
    w_imm32  = '0;
    o_fields.fmt     = w_fmt;
    o_fields.illegal = (w_fmt == FMT_ILL);
    if (w_fmt != FMT_ILL) o_fields.opcode = i_inst[6:0];
    case (w_fmt)
      FMT_R: begin
        o_fields.rd     = i_inst[11:7];
        o_fields.rs1    = i_inst[19:15];
        o_fields.rs2    = i_inst[24:20];
        o_fields.funct3 = i_inst[14:12];
        o_fields.funct7 = i_inst[31:25];
      end
      FMT_I: begin
        o_fields.rd     = i_inst[11:7];
        o_fields.rs1    = i_inst[19:15];
        o_fields.funct3 = i_inst[14:12];
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
      end
      FMT_S: begin
        o_fields.rs1    = i_inst[19:15];
        o_fields.rs2    = i_inst[24:20];
        o_fields.funct3 = i_inst[14:12];
        w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      end
      FMT_B: begin
        o_fields.rs1    = i_inst[19:15];
        o_fields.rs2    = i_inst[24:20];
        o_fields.funct3 = i_inst[14:12];
        w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
      end
      FMT_U: begin
        o_fields.rd = i_inst[11:7];
        w_imm32 = {i_inst[31:12], 12'b0};
      end
      FMT_J: begin
        o_fields.rd = i_inst[11:7];
        w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};
      end
      default: ;
    endcase
  end

  // Every format's immediate fits in 32 bits; widen once with sign extension.
  assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/inst_dec_stage.sv
// Registered valid/ready RV32I decode stage with a two-entry skid buffer.
// Define INST_DEC_PERF_CNT_EN to build the saturating dec_cnt/ill_cnt counters.
module inst_dec_stage
  import inst_dec_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instruction_word,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [2:0]       fmt,
  output logic [6:0]       opcode,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic             illegal,
  output logic [CNT_W-1:0] dec_cnt,
  output logic [CNT_W-1:0] ill_cnt,
  output logic [1:0]       dbg_state
);

  // Handshake: a transfer happens on a rising edge where valid && ready; a
  // source holds valid and data stable until that edge, and out_valid/bundle
  // stay stable until emitted. in_ready comes only from state (no out_ready path).

  skid_state_e     r_state;
  skid_state_e     w_next_state;
  dec_fields_t     r_main;
  dec_fields_t     r_skid;
  logic [XLEN-1:0] r_main_imm;
  logic [XLEN-1:0] r_skid_imm;
  dec_fields_t     w_dec;
  logic [XLEN-1:0] w_dec_imm;
  logic            w_accept;
  logic            w_emit;
  logic            w_load_main;
  logic            w_load_skid;
  logic            w_skid_to_main;

  inst_dec_fields #(.XLEN(XLEN)) u_fields (
    .i_inst   (instruction_word),
    .o_fields (w_dec),
    .o_imm    (w_dec_imm)
  );

  assign in_ready  = (r_state != ST_FULL2);
  assign out_valid = (r_state != ST_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_emit    = out_valid && out_ready;
  assign dbg_state = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state   = r_state;
    w_load_main    = 1'b0;
    w_load_skid    = 1'b0;
    w_skid_to_main = 1'b0;
    if (flush) begin
      w_next_state = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_accept) begin
            w_next_state = ST_FULL1;
            w_load_main  = 1'b1;
          end
        end
        ST_FULL1: begin
          if (w_accept && !w_emit) begin
            w_next_state = ST_FULL2;
            w_load_skid  = 1'b1;
          end else if (w_accept && w_emit) begin
            w_load_main = 1'b1;
          end else if (w_emit) begin
            w_next_state = ST_EMPTY;
          end
        end
        ST_FULL2: begin
          if (w_emit) begin
            w_next_state   = ST_FULL1;
            w_skid_to_main = 1'b1;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main     <= '0;
      r_main_imm <= '0;
      r_skid     <= '0;
      r_skid_imm <= '0;
    end else begin
      if (w_load_main) begin
        r_main     <= w_dec;
        r_main_imm <= w_dec_imm;
      end else if (w_skid_to_main) begin
        r_main     <= r_skid;
        r_main_imm <= r_skid_imm;
      end
      if (w_load_skid) begin
        r_skid     <= w_dec;
        r_skid_imm <= w_dec_imm;
      end
    end
  end

  assign fmt     = r_main.fmt;
  assign opcode  = r_main.opcode;
  assign rd      = r_main.rd;
  assign rs1     = r_main.rs1;
  assign rs2     = r_main.rs2;
  assign funct3  = r_main.funct3;
  assign funct7  = r_main.funct7;
  assign illegal = r_main.illegal;
  assign imm     = r_main_imm;

`ifdef INST_DEC_PERF_CNT_EN
  logic [CNT_W-1:0] r_dec_cnt;
  logic [CNT_W-1:0] r_ill_cnt;
  logic             w_count;

  // A flushed emit is discarded, so it must not be counted.
  assign w_count = w_emit && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dec_cnt <= '0;
      r_ill_cnt <= '0;
    end else if (w_count) begin
      if (r_dec_cnt != '1) r_dec_cnt <= r_dec_cnt + CNT_W'(1);
      if (r_main.illegal && (r_ill_cnt != '1)) r_ill_cnt <= r_ill_cnt + CNT_W'(1);
    end
  end

  assign dec_cnt = r_dec_cnt;
  assign ill_cnt = r_ill_cnt;
`else
  assign dec_cnt = '0;
  assign ill_cnt = '0;
`endif

endmodule

// File: tb/tb_inst_dec_stage.sv
// Bench for inst_dec_stage: directed test-plan cases plus randomized traffic
// checked by a scoreboard against a behavioural RV32I decode model.
module tb_inst_dec_stage;

  localparam int XLEN  = 32;
  localparam int CNT_W = 4;
  localparam int BW    = 36 + XLEN;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [31:0]      instruction_word = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [2:0]       fmt;
  logic [6:0]       opcode;
  logic [4:0]       rd;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic [2:0]       funct3;
  logic [6:0]       funct7;
  logic [XLEN-1:0]  imm;
  logic             illegal;
  logic [CNT_W-1:0] dec_cnt;
  logic [CNT_W-1:0] ill_cnt;
  logic [1:0]       dbg_state;

  inst_dec_stage #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .fmt              (fmt),
    .opcode           (opcode),
    .rd               (rd),
    .rs1              (rs1),
    .rs2              (rs2),
    .funct3           (funct3),
    .funct7           (funct7),
    .imm              (imm),
    .illegal          (illegal),
    .dec_cnt          (dec_cnt),
    .ill_cnt          (ill_cnt),
    .dbg_state        (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [BW-1:0] exp_q[$];
  int            n_tests = 0;
  int            n_fail = 0;
  int            m_dec = 0;
  int            m_ill = 0;
  int            emit_cnt = 0;
  logic          hs_last = 1'b0;
  logic [BW-1:0] w_act;
  logic [6:0]    opc_tab [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111,
                                 7'b1110011, 7'b0001111, 7'b0100011, 7'b1100011,
                                 7'b1101111};

  assign w_act = {fmt, opcode, rd, rs1, rs2, funct3, funct7, illegal, imm};

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int sat(input int n);
`ifdef INST_DEC_PERF_CNT_EN
    return (n > (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : n;
`else
    return 0 * n;
`endif
  endfunction

  // Reference decode: fields chosen by format, immediate built as an integer value.
  function automatic logic [BW-1:0] ref_decode(input logic [31:0] w);
    int         f;
    longint     v;
    logic [63:0] v64;
    logic [6:0] e_op;
    logic [4:0] e_rd, e_rs1, e_rs2;
    logic [2:0] e_f3;
    logic [6:0] e_f7;
    case (w[6:0])
      7'b0110011:                                         f = 0;
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011,
      7'b0001111:                                         f = 1;
      7'b0100011:                                         f = 2;
      7'b1100011:                                         f = 3;
      7'b0110111, 7'b0010111:                             f = 4;
      7'b1101111:                                         f = 5;
      default:                                            f = 7;
    endcase
    if (w[1:0] != 2'b11) f = 7;
    e_op = '0; e_rd = '0; e_rs1 = '0; e_rs2 = '0; e_f3 = '0; e_f7 = '0; v = 0;
    if (f != 7) e_op = w[6:0];
    if (f == 0 || f == 1 || f == 4 || f == 5) e_rd = w[11:7];
    if (f <= 3) begin
      e_rs1 = w[19:15];
      e_f3  = w[14:12];
    end
    if (f == 0 || f == 2 || f == 3) e_rs2 = w[24:20];
    if (f == 0) e_f7 = w[31:25];
    case (f)
      1: begin
        v = longint'(w[31:20]);
        if (v >= 2048) v -= 4096;
      end
      2: begin
        v = longint'(w[31:25]) * 32 + longint'(w[11:7]);
        if (v >= 2048) v -= 4096;
      end
      3: begin
        v = longint'(w[31]) * 4096 + longint'(w[7]) * 2048 +
            longint'(w[30:25]) * 32 + longint'(w[11:8]) * 2;
        if (w[31]) v -= 8192;
      end
      4: begin
        v = longint'(w[31:12]) * 4096;
        if (w[31]) v -= 64'sd4294967296;
      end
      5: begin
        v = longint'(w[31]) * 1048576 + longint'(w[19:12]) * 4096 +
            longint'(w[20]) * 2048 + longint'(w[30:21]) * 2;
        if (w[31]) v -= 2097152;
      end
      default: v = 0;
    endcase
    v64 = v;
    return {f[2:0], e_op, e_rd, e_rs1, e_rs2, e_f3, e_f7, (f == 7), v64[XLEN-1:0]};
  endfunction

  function automatic logic [31:0] gen_word();
    logic [31:0] w;
    int          k;
    w = $urandom();
    k = $urandom_range(0, 11);
    if (k < 9) w[6:0] = opc_tab[k];
    else if (k == 9) w[6:0] = 7'b0110111;
    else if (k == 10) w[1:0] = 2'($urandom_range(0, 2));
    return w;
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_q.delete();
      m_dec = 0;
      m_ill = 0;
      hs_last = 1'b0;
    end else begin
      logic [BW-1:0] e;
      chk("out_valid_occupancy", out_valid, exp_q.size() > 0);
      chk("in_ready_occupancy", in_ready, exp_q.size() < 2);
      hs_last = in_valid && in_ready;
      if (flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready && exp_q.size() > 0) begin
          emit_cnt++;
          chk("dec_cnt_at_emit", dec_cnt, sat(m_dec));
          chk("ill_cnt_at_emit", ill_cnt, sat(m_ill));
          e = exp_q.pop_front();
          chk("bundle", w_act, e);
          m_dec++;
          if (e[XLEN]) m_ill++;
        end
        if (in_valid && in_ready) exp_q.push_back(ref_decode(instruction_word));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_single(input logic [31:0] w);
    in_valid = 1'b1;
    instruction_word = w;
    out_ready = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_fmt", fmt, 3'd0);
    chk("rst_imm", imm, '0);
    chk("rst_rd", rd, 5'd0);
    chk("rst_dec_cnt", dec_cnt, '0);
    chk("rst_ill_cnt", ill_cnt, '0);
    chk("rst_state", dbg_state, 2'd0);
    rst_n = 1'b1;
    step();

    // sw x5,8(x2)
    send_single(32'h00512423);
    chk("sw_valid", out_valid, 1'b1);
    chk("sw_fmt", fmt, 3'd2);
    chk("sw_rs1", rs1, 5'd2);
    chk("sw_rs2", rs2, 5'd5);
    chk("sw_rd", rd, 5'd0);
    chk("sw_funct3", funct3, 3'd2);
    chk("sw_imm", imm, 32'd8);
    // beq x0,x0,-4
    send_single(32'hFE000EE3);
    chk("beq_fmt", fmt, 3'd3);
    chk("beq_imm", imm, 32'hFFFFFFFC);
    chk("beq_rd", rd, 5'd0);
    // lui x1,0x12345
    send_single(32'h123450B7);
    chk("lui_fmt", fmt, 3'd4);
    chk("lui_rd", rd, 5'd1);
    chk("lui_imm", imm, 32'h12345000);
    chk("lui_rs1", rs1, 5'd0);
    chk("lui_rs2", rs2, 5'd0);
    step();
    chk("drain_after_lui", out_valid, 1'b0);

    // backpressure: three back-to-back words
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction_word = 32'h00100093;
    step();
    chk("bp_ready_after_1", in_ready, 1'b1);
    instruction_word = 32'h00200113;
    step();
    chk("bp_ready_after_2", in_ready, 1'b0);
    instruction_word = 32'h00300193;
    repeat (2) step();
    chk("bp_held_ready", in_ready, 1'b0);
    chk("bp_held_valid", out_valid, 1'b1);
    chk("bp_full2_state", dbg_state, 2'b11);
    base = emit_cnt;
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("bp_three_emits_no_bubble", emit_cnt - base, 3);
    chk("bp_drained", out_valid, 1'b0);

    // flush while FULL2 with a pending input
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction_word = 32'h00B50533;
    step();
    instruction_word = 32'h0000006F;
    step();
    instruction_word = 32'h00000013;
    flush = 1'b1;
    step();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", out_valid, 1'b0);
    chk("flush_in_ready", in_ready, 1'b1);
    chk("flush_dec_cnt", dec_cnt, sat(m_dec));
    chk("flush_ill_cnt", ill_cnt, sat(m_ill));
    step();

    // illegal word after a fresh reset, then reset mid-stream
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send_single(32'h00000000);
    chk("ill_flag", illegal, 1'b1);
    chk("ill_fmt", fmt, 3'd7);
    chk("ill_imm", imm, '0);
    chk("ill_opcode", opcode, 7'd0);
    step();
    chk("ill_cnt_one", ill_cnt, sat(1));
    chk("ill_dec_cnt_one", dec_cnt, sat(1));
    out_ready = 1'b0;
    in_valid = 1'b1;
    instruction_word = 32'h123450B7;
    step();
    instruction_word = 32'h00512423;
    step();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_in_ready", in_ready, 1'b1);
    chk("midrst_fmt", fmt, 3'd0);
    chk("midrst_imm", imm, '0);
    chk("midrst_rd", rd, 5'd0);
    chk("midrst_illegal", illegal, 1'b0);
    chk("midrst_dec_cnt", dec_cnt, '0);
    chk("midrst_ill_cnt", ill_cnt, '0);
    step();
    rst_n = 1'b1;
    step();

    // randomized traffic
    repeat (600) begin
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 39) == 0);
      if (!in_valid || hs_last) begin
        in_valid = ($urandom_range(0, 9) < 7);
        instruction_word = gen_word();
      end
      step();
    end

    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    chk("final_queue_empty", exp_q.size(), 0);
    chk("final_out_valid", out_valid, 1'b0);
    chk("final_dec_cnt", dec_cnt, sat(m_dec));
    chk("final_ill_cnt", ill_cnt, sat(m_ill));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
